// File: rtl/temp_valve_ctrl_if.sv
// Handshake bundle between the wash sequencer, the level sensor and the inlet valve controller.
// master drives the requests and the sensor input; slave is the controller itself.
interface temp_valve_ctrl_if;
  logic [1:0] iEstado_Temp;
  logic       iStart;
  logic       iAbort;
  logic       iNivel_Lleno;
  logic       oValvula_Caliente;
  logic       oValvula_Fria;
  logic       oLlenando;
  logic       oListo;
  logic       oError;
  logic [2:0] oEstado_Fsm;

  modport master (
    output iEstado_Temp, iStart, iAbort, iNivel_Lleno,
    input  oValvula_Caliente, oValvula_Fria, oLlenando, oListo, oError, oEstado_Fsm
  );

  modport slave (
    input  iEstado_Temp, iStart, iAbort, iNivel_Lleno,
    output oValvula_Caliente, oValvula_Fria, oLlenando, oListo, oError, oEstado_Fsm
  );
endinterface

// File: rtl/temp_valve_ctrl.sv
// Inlet valve controller: fills the tank at the latched temperature until the level settles full.
// Optional TEMP_VALVE_DEADTIME_EN inserts a closed cycle at every hot/cold switch in tibia mode.
module temp_valve_ctrl #(
  parameter int unsigned MIX_PERIOD    = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned FILL_TIMEOUT  = 1000
) (
  input logic              iClk,
  input logic              iReset_Temperatura,
  temp_valve_ctrl_if.slave ctrl_io
);

  localparam int unsigned MixW = (MIX_PERIOD > 2) ? $clog2(MIX_PERIOD) : 1;
  localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [MixW-1:0] MixLast = MixW'(MIX_PERIOD - 1);
  localparam logic [MixW-1:0] MixHalf = MixW'(MIX_PERIOD / 2);
  localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYCLES - 1);
  localparam logic [15:0]     TmoLast = 16'(FILL_TIMEOUT - 1);

  localparam logic [1:0] CodeAmb  = 2'b00;
  localparam logic [1:0] CodeHot  = 2'b01;
  localparam logic [1:0] CodeTib  = 2'b10;
  localparam logic [1:0] CodeCold = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFill   = 3'd1,
    StSettle = 3'd2,
    StDone   = 3'd3,
    StFault  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      code_q, code_d;
  logic [MixW-1:0] mix_q, mix_d;
  logic [SetW-1:0] set_q, set_d;
  logic [15:0]     tmo_q, tmo_d;
  logic            lvl_meta_q, lvl_s_q;
  logic            hot_q, hot_d;
  logic            cold_q, cold_d;
  logic            start, abort;

  assign start = ctrl_io.iStart;
  assign abort = ctrl_io.iAbort;

  always_ff @(posedge iClk or negedge iReset_Temperatura) begin
    if (!iReset_Temperatura) begin
      state_q    <= StIdle;
      code_q     <= CodeAmb;
      mix_q      <= '0;
      set_q      <= '0;
      tmo_q      <= '0;
      lvl_meta_q <= 1'b0;
      lvl_s_q    <= 1'b0;
      hot_q      <= 1'b0;
      cold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      mix_q      <= mix_d;
      set_q      <= set_d;
      tmo_q      <= tmo_d;
      lvl_meta_q <= ctrl_io.iNivel_Lleno;
      lvl_s_q    <= lvl_meta_q;
      hot_q      <= hot_d;
      cold_q     <= cold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    mix_d   = mix_q;
    set_d   = set_q;
    tmo_d   = tmo_q;
    case (state_q)
      StIdle, StFault: begin
        if (start) begin
          code_d  = ctrl_io.iEstado_Temp;
          mix_d   = '0;
          set_d   = '0;
          tmo_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        mix_d = (mix_q == MixLast) ? '0 : mix_q + MixW'(1);
        tmo_d = tmo_q + 16'd1;
        if (lvl_s_q) state_d = StSettle;
        if (tmo_q == TmoLast) state_d = StFault;
      end
      StSettle: begin
        // mix restarts from 0 whenever the level bounces back to FILL
        mix_d = '0;
        tmo_d = tmo_q + 16'd1;
        if (lvl_s_q) begin
          if (set_q == SetLast) state_d = StDone;
          else                  set_d   = set_q + SetW'(1);
        end else begin
          set_d   = '0;
          state_d = StFill;
        end
        if (tmo_q == TmoLast) state_d = StFault;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      mix_d   = '0;
      set_d   = '0;
      tmo_d   = '0;
    end
  end

  // Valves follow the current state, so they lag state changes by one cycle.
  always_comb begin
    hot_d  = 1'b0;
    cold_d = 1'b0;
    if (state_q == StFill && !abort) begin
      unique case (code_q)
        CodeHot:  hot_d = 1'b1;
        CodeCold: cold_d = 1'b1;
        CodeAmb: begin
          hot_d  = 1'b1;
          cold_d = 1'b1;
        end
        CodeTib: begin
`ifdef TEMP_VALVE_DEADTIME_EN
          hot_d  = (mix_q != '0) && (mix_q < MixHalf);
          cold_d = (mix_q > MixHalf);
`else
          hot_d  = (mix_q < MixHalf);
          cold_d = !(mix_q < MixHalf);
`endif
        end
      endcase
    end
  end

  assign ctrl_io.oValvula_Caliente = hot_q;
  assign ctrl_io.oValvula_Fria     = cold_q;
  assign ctrl_io.oLlenando         = (state_q == StFill) || (state_q == StSettle);
  assign ctrl_io.oListo            = (state_q == StDone);
  assign ctrl_io.oError            = (state_q == StFault);
  assign ctrl_io.oEstado_Fsm       = state_q;

endmodule

// File: tb/tb_temp_valve_ctrl.sv
// Directed bench for temp_valve_ctrl: caliente, tibia, timeout, settle bounce, abort, async reset.
// Expected tibia pattern follows TEMP_VALVE_DEADTIME_EN when defined.
module tb_temp_valve_ctrl;
  logic iClk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 iClk = ~iClk;

  temp_valve_ctrl_if bus ();

  temp_valve_ctrl #(
    .MIX_PERIOD   (8),
    .SETTLE_CYCLES(4),
    .FILL_TIMEOUT (50)
  ) dut (
    .iClk              (iClk),
    .iReset_Temperatura(rst_n),
    .ctrl_io           (bus)
  );

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int st, input int hot, input int cold,
                         input int fill, input int done, input int err);
    chk({tag, ".state"}, 16'(bus.oEstado_Fsm), 16'(st));
    chk({tag, ".hot"}, 16'(bus.oValvula_Caliente), 16'(hot));
    chk({tag, ".cold"}, 16'(bus.oValvula_Fria), 16'(cold));
    chk({tag, ".fill"}, 16'(bus.oLlenando), 16'(fill));
    chk({tag, ".done"}, 16'(bus.oListo), 16'(done));
    chk({tag, ".err"}, 16'(bus.oError), 16'(err));
  endtask

  initial begin
    int m;
    int eh;
    int ec;
    bus.iEstado_Temp = 2'b00;
    bus.iStart       = 1'b0;
    bus.iAbort       = 1'b0;
    bus.iNivel_Lleno = 1'b0;

    // Reset
    #2 rst_n = 1'b0;
    #1 chk_out("rst_async", 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("rst_idle", 0, 0, 0, 0, 0, 0);

    // Caliente fill
    bus.iEstado_Temp = 2'b01;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    bus.iEstado_Temp = 2'b11;
    chk_out("cal_entry", 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 19; i++) begin
      tick();
      chk_out("cal_fill", 1, 1, 0, 1, 0, 0);
    end
    bus.iNivel_Lleno = 1'b1;
    tick();
    chk_out("cal_sync1", 1, 1, 0, 1, 0, 0);
    tick();
    chk_out("cal_sync2", 1, 1, 0, 1, 0, 0);
    tick();
    chk_out("cal_settle0", 2, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("cal_settle", 2, 0, 0, 1, 0, 0);
    end
    tick();
    chk_out("cal_done", 3, 0, 0, 0, 1, 0);
    tick();
    chk_out("cal_idle", 0, 0, 0, 0, 0, 0);
    bus.iNivel_Lleno = 1'b0;
    tick();
    tick();

    // Tibia mixing
    bus.iEstado_Temp = 2'b10;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    chk_out("tib_entry", 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 32; i++) begin
      tick();
      m = i % 8;
`ifdef TEMP_VALVE_DEADTIME_EN
      eh = (m >= 1 && m <= 3) ? 1 : 0;
      ec = (m >= 5) ? 1 : 0;
`else
      eh = (m < 4) ? 1 : 0;
      ec = (m < 4) ? 0 : 1;
`endif
      chk("tib.hot", 16'(bus.oValvula_Caliente), 16'(eh));
      chk("tib.cold", 16'(bus.oValvula_Fria), 16'(ec));
    end

    // Async reset mid-tibia, no clock edge
    rst_n = 1'b0;
    #1 chk_out("arst_now", 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("arst_idle", 0, 0, 0, 0, 0, 0);
    chk("arst.code", 16'(dut.code_q), 16'd0);

    // Timeout with fria
    bus.iEstado_Temp = 2'b11;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    chk_out("tmo_entry", 1, 0, 0, 1, 0, 0);
    for (int i = 1; i < 50; i++) begin
      tick();
      chk("tmo.state", 16'(bus.oEstado_Fsm), 16'd1);
      chk("tmo.cold", 16'(bus.oValvula_Fria), 16'd1);
    end
    tick();
    chk_out("tmo_fault", 4, 0, 1, 0, 0, 1);
    tick();
    chk_out("tmo_closed", 4, 0, 0, 0, 0, 1);
    tick();
    chk_out("tmo_sticky", 4, 0, 0, 0, 0, 1);
    bus.iEstado_Temp = 2'b01;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    chk_out("tmo_restart", 1, 0, 0, 1, 0, 0);
    tick();
    chk_out("tmo_refill", 1, 1, 0, 1, 0, 0);
    bus.iAbort = 1'b1;
    tick();
    bus.iAbort = 1'b0;
    chk_out("tmo_abort", 0, 0, 0, 0, 0, 0);

    // Settle bounce
    bus.iEstado_Temp = 2'b01;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    tick();
    tick();
    tick();
    bus.iNivel_Lleno = 1'b1;
    tick();
    tick();
    bus.iNivel_Lleno = 1'b0;
    tick();
    chk_out("bnc_settle1", 2, 1, 0, 1, 0, 0);
    bus.iNivel_Lleno = 1'b1;
    tick();
    chk_out("bnc_settle2", 2, 0, 0, 1, 0, 0);
    tick();
    chk_out("bnc_back", 1, 0, 0, 1, 0, 0);
    tick();
    chk_out("bnc_resettle", 2, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bnc_count", 2, 0, 0, 1, 0, 0);
    end
    tick();
    chk_out("bnc_done", 3, 0, 0, 0, 1, 0);
    tick();
    chk_out("bnc_idle", 0, 0, 0, 0, 0, 0);
    bus.iNivel_Lleno = 1'b0;
    tick();
    tick();

    // Abort during ambiente, together with start
    bus.iEstado_Temp = 2'b00;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    chk_out("amb_entry", 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_out("amb_fill", 1, 1, 1, 1, 0, 0);
    end
    bus.iAbort = 1'b1;
    bus.iStart = 1'b1;
    tick();
    chk_out("amb_abort", 0, 0, 0, 0, 0, 0);
    bus.iAbort = 1'b0;
    bus.iStart = 1'b0;
    tick();
    chk_out("amb_idle", 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/temp_valve_ctrl.md
Name: temp_valve_ctrl

Overview:
- Downstream consumer of the water-temperature selector.
- Takes the 2-bit temperature code plus a fill request and drives the hot and cold inlet valves until the level sensor reports full.
- Tibia (warm) is produced by time-multiplexing the hot and cold valves.
- Provides a fill timeout fault, an abort, and a done pulse for the wash sequencer.

Parameters:
- MIX_PERIOD, 8: cycles per tibia mixing period; hot open for the first MIX_PERIOD/2, cold for the rest. Even, >=2.
- SETTLE_CYCLES, 4: consecutive synchronized full-level cycles required before done. >=1.
- FILL_TIMEOUT, 1000: max cycles spent in FILL+SETTLE before fault. Fits in 16 bits.

Ports:
- iClk, in, 1: system clock, rising edge.
- iReset_Temperatura, in, 1: reset, asynchronous, active-low.
- iEstado_Temp, in, 2: temperature code. 00 ambiente, 01 caliente, 10 tibia, 11 fria.
- iStart, in, 1: fill request, sampled on rising clock edge; level, any width.
- iAbort, in, 1: synchronous abort, highest priority after reset.
- iNivel_Lleno, in, 1: asynchronous level sensor, 1 = full.
- oValvula_Caliente, out, 1: hot valve open.
- oValvula_Fria, out, 1: cold valve open.
- oLlenando, out, 1: high in FILL and SETTLE.
- oListo, out, 1: one-cycle done pulse.
- oError, out, 1: timeout fault, sticky.
- oEstado_Fsm, out, 3: state encoding. IDLE=0, FILL=1, SETTLE=2, DONE=3, FAULT=4.

Behaviour:
- Reset (async, active-low):
  - State IDLE; all outputs 0.
  - Mix, settle and timeout counters 0; latched code 00; both level synchronizer flops 0.
- Level sensor: 2-flop synchronizer; lvl_s lags iNivel_Lleno by 2 cycles.
- IDLE:
  - Valves closed.
  - iStart=1 → latch iEstado_Temp, clear counters, go to FILL next cycle.
- FILL:
  - Valves driven from the latched code, registered, so they change the cycle after the state changes:
    - caliente: hot only.
    - fria: cold only.
    - ambiente: both open.
    - tibia: hot while mix_cnt < MIX_PERIOD/2, else cold. mix_cnt runs 0..MIX_PERIOD-1, wraps, and restarts at 0 on FILL entry.
  - lvl_s=1 → SETTLE.
- SETTLE:
  - Valves closed.
  - settle_cnt increments while lvl_s=1.
  - lvl_s=0 → back to FILL, settle_cnt=0, mix_cnt restarts.
  - settle_cnt reaches SETTLE_CYCLES-1 with lvl_s=1 → DONE.
- Timeout:
  - Timeout counter increments every cycle in FILL or SETTLE and is not cleared on a SETTLE→FILL bounce.
  - Counter == FILL_TIMEOUT-1 → FAULT. Timeout wins over a simultaneous SETTLE→DONE transition.
- DONE:
  - oListo=1 for exactly this one cycle; valves closed.
  - Unconditionally → IDLE.
- FAULT:
  - Valves closed; oError=1.
  - Stays in FAULT until iStart=1, which clears oError, latches a new code and enters FILL.
- iAbort=1 in any state: next state IDLE, valves closed next cycle, counters cleared, oError cleared.
- iStart while in FILL, SETTLE or DONE is ignored.
- iEstado_Temp changes after the latch are ignored until the next start.
- iStart and iAbort together: abort wins.
- Start with tank already full: FILL lasts until lvl_s rises (≥1 cycle), then normal SETTLE.
- Reset asserted mid-fill closes both valves immediately (asynchronous).

Optional Feature:
- Macro: TEMP_VALVE_DEADTIME_EN.
- Defined: in tibia, every hot↔cold switch, including the wrap at mix_cnt=0, inserts one cycle with both valves closed in place of the first cycle of the new half. Hot and cold are never open in adjacent cycles.
- Undefined: direct switch with no gap.
- Ambiente, caliente and fria behave the same with or without the macro.

Test Plan:
- Caliente fill:
  - Stimulus: code 01, iStart pulse, iNivel_Lleno raised 20 cycles later, held.
  - Required: hot=1 and cold=0 throughout FILL; SETTLE 4 cycles; oListo pulses once; back in IDLE; oError=0.
- Tibia mixing, MIX_PERIOD=8, macro undefined:
  - Stimulus: code 10, start, level held low for 32 cycles.
  - Required: hot pattern 11110000 repeated 4×, cold its complement.
  - With macro defined: hot 01110000, cold 00000111, repeating.
- Timeout, FILL_TIMEOUT=50:
  - Stimulus: code 11, start, level never asserted.
  - Required: oError=1 and state=4 after exactly 50 FILL cycles; valves closed.
  - Follow-up: new iStart clears oError and enters FILL.
- Settle bounce:
  - Stimulus: level high 2 cycles, low 1, then high.
  - Required: SETTLE→FILL→SETTLE; oListo only after 4 consecutive high synchronized cycles.
- Abort/ambiente:
  - Stimulus: code 00, start, iAbort at cycle 10 together with iStart.
  - Required: both valves open cycles 1–10, closed from cycle 11; IDLE; no oListo.
- Async reset:
  - Stimulus: assert reset mid-tibia with no clock edge.
  - Required: all outputs 0 immediately; after release, IDLE with code 00 latched.
